out_lane_packer: RTL and testbench

OUT_LANE_PACKER -- requirements
Module: out_lane_packer

---
 rtl/out_lane_packer.sv | 164 ++++++++++++++++
 tb/tb_out_lane_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/out_lane_packer.sv
// Requantises accumulator words, packs them into NUM_LANES-wide groups and streams
// the groups out through a FIFO behind a bus turnaround FSM. Optional: OUT_LANE_PACKER_SAT_COUNT_EN.
module out_lane_packer #(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int ACCUMULATION_WIDTH = 32,
   parameter int NUM_LANES          = 3,
   parameter int DEPTH              = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_in,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [ACCUMULATION_WIDTH-1:0]        in_data,
   input  logic                                 in_last,
   input  logic [$clog2(ACCUMULATION_WIDTH)-1:0] shift_amt,
   output logic [NUM_LANES*IO_DATA_WIDTH-1:0]   out_data,
   output logic [NUM_LANES-1:0]                 out_lane_mask,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 driving_cons,
   output logic [15:0]                          sat_count
);
   localparam int IW  = IO_DATA_WIDTH;
   localparam int ACW = ACCUMULATION_WIDTH;
   localparam int GW  = NUM_LANES * IW;
   localparam int SW  = $clog2(ACW);
   localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int PW  = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, TURN, DRIVE, REL} state_t;

   logic signed [ACW:0]   rnd, sum_ext, shifted;
   logic [ACW-IW+1:0]     upper;
   logic                  sat;
   logic [IW-1:0]         rq_word;

   logic [GW-1:0]         pack_data_q, pack_data_d, ins_data;
   logic [NUM_LANES-1:0]  pack_mask_q, pack_mask_d, ins_mask;
   logic [LW-1:0]         lane_idx_q, lane_idx_d;
   logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [GW-1:0]         fifo_data_q [DEPTH];
   logic [NUM_LANES-1:0]  fifo_mask_q [DEPTH];
   logic                  xfer, push, pop, full, empty;
   state_t                state_q;
   logic                  driving_q;

   // Round half up before the shift; one extra bit keeps the add from overflowing.
   always_comb begin
      rnd = '0;
      if (shift_amt != '0) rnd[shift_amt - SW'(1)] = 1'b1;
      sum_ext = $signed({in_data[ACW-1], in_data}) + rnd;
      shifted = sum_ext >>> shift_amt;
      upper   = shifted[ACW:IW-1];
      sat     = !((&upper) || !(|upper));
      if (!sat)               rq_word = shifted[IW-1:0];
      else if (shifted[ACW])  rq_word = {1'b1, {(IW-1){1'b0}}};
      else                    rq_word = {1'b0, {(IW-1){1'b1}}};
   end

   assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign in_ready = !full;
   assign xfer     = in_valid && in_ready;
   assign push     = xfer && (in_last || (lane_idx_q == LW'(NUM_LANES - 1)));
   assign out_valid = (state_q == DRIVE) && !empty;
   assign pop      = out_valid && out_ready;

   always_comb begin
      ins_data = pack_data_q;
      ins_mask = pack_mask_q;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (lane_idx_q == LW'(k)) begin
            ins_data[k*IW +: IW] = rq_word;
            ins_mask[k]          = 1'b1;
         end
      end
      pack_data_d = pack_data_q;
      pack_mask_d = pack_mask_q;
      lane_idx_d  = lane_idx_q;
      if (push) begin
         pack_data_d = '0;
         pack_mask_d = '0;
         lane_idx_d  = '0;
      end else if (xfer) begin
         pack_data_d = ins_data;
         pack_mask_d = ins_mask;
         lane_idx_d  = lane_idx_q + LW'(1);
      end
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         pack_data_q <= '0;
         pack_mask_q <= '0;
         lane_idx_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         pack_data_q <= pack_data_d;
         pack_mask_q <= pack_mask_d;
         lane_idx_q  <= lane_idx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Storage needs no reset: pointers define occupancy and out_data is gated by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q[PW-1:0]] <= ins_data;
         fifo_mask_q[wr_ptr_q[PW-1:0]] <= ins_mask;
      end
   end

   assign out_data      = out_valid ? fifo_data_q[rd_ptr_q[PW-1:0]] : '0;
   assign out_lane_mask = out_valid ? fifo_mask_q[rd_ptr_q[PW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q   <= IDLE;
         driving_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (!empty) begin
               state_q   <= TURN;
               driving_q <= 1'b1;
            end
            TURN:    state_q <= DRIVE;
            DRIVE:   if (empty) state_q <= REL;
            REL: begin
               state_q   <= IDLE;
               driving_q <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               driving_q <= 1'b0;
            end
         endcase
      end
   end

   assign driving_cons = driving_q;

`ifdef OUT_LANE_PACKER_SAT_COUNT_EN
   logic [15:0] sat_count_q, sat_count_d;

   always_comb begin
      sat_count_d = sat_count_q;
      if (xfer && sat && (sat_count_q != 16'hFFFF)) sat_count_d = sat_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst_in) sat_count_q <= '0;
      else        sat_count_q <= sat_count_d;
   end

   assign sat_count = sat_count_q;
`else
   assign sat_count = '0;
`endif

endmodule

// File: tb/tb_out_lane_packer.sv
// Directed bench for out_lane_packer at default parameters.
module tb_out_lane_packer;
   logic        clk = 1'b0;
   logic        rst_in, in_valid, in_ready, in_last, out_valid, out_ready, driving_cons;
   logic [31:0] in_data;
   logic [4:0]  shift_amt;
   logic [47:0] out_data;
   logic [2:0]  out_lane_mask;
   logic [15:0] sat_count;
   int checks = 0;
   int failures = 0;

`ifdef OUT_LANE_PACKER_SAT_COUNT_EN
   localparam logic [15:0] SC_ONE = 16'd1, SC_TWO = 16'd2;
`else
   localparam logic [15:0] SC_ONE = 16'd0, SC_TWO = 16'd0;
`endif

   out_lane_packer dut (
      .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .shift_amt(shift_amt),
      .out_data(out_data), .out_lane_mask(out_lane_mask), .out_valid(out_valid),
      .out_ready(out_ready), .driving_cons(driving_cons), .sat_count(sat_count)
   );

   always #5 clk = ~clk;

   // Called at a negedge; the word transfers on the next posedge.
   task automatic send(input logic [31:0] d, input logic [4:0] s, input logic l);
      in_valid = 1'b1; in_data = d; shift_amt = s; in_last = l;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, driving_cons} !== 3'b100) begin
         failures++;
         $display("FAIL reset_ctrl: ready/valid/drv=%b required 100", {in_ready, out_valid, driving_cons});
      end
      checks++;
      if ({out_data, out_lane_mask, sat_count} !== 67'd0) begin
         failures++;
         $display("FAIL reset_data: data=%h mask=%b sat=%0d required all 0", out_data, out_lane_mask, sat_count);
      end
      rst_in = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      out_ready = 1'b1;
      send(32'd1, 5'd0, 1'b0);
      send(32'd2, 5'd0, 1'b0);
      send(32'd3, 5'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL basic_push_cycle: out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, driving_cons} !== 2'b01) begin
         failures++; $display("FAIL basic_turn: valid/drv=%b required 01", {out_valid, driving_cons});
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 48'h0003_0002_0001 || out_lane_mask !== 3'b111) begin
         failures++;
         $display("FAIL basic_group: valid=%b data=%h mask=%b required 1 000300020001 111", out_valid, out_data, out_lane_mask);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, driving_cons} !== 2'b01) begin
         failures++; $display("FAIL basic_popped: valid/drv=%b required 01", {out_valid, driving_cons});
      end
      @(negedge clk);
      checks++;
      if (driving_cons !== 1'b1) begin
         failures++; $display("FAIL basic_rel: driving_cons=%b required 1", driving_cons);
      end
      @(negedge clk);
      checks++;
      if (driving_cons !== 1'b0) begin
         failures++; $display("FAIL basic_idle: driving_cons=%b required 0", driving_cons);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b1;
      send(32'h0001_0000, 5'd0, 1'b0);
      checks++;
      if (sat_count !== SC_ONE) begin
         failures++; $display("FAIL sat_count_one: sat_count=%0d required %0d", sat_count, SC_ONE);
      end
      send(32'hFFFF_0000, 5'd0, 1'b1);
      wait_valid("sat_wait");
      checks++;
      if (out_data !== 48'h0000_8000_7FFF || out_lane_mask !== 3'b011) begin
         failures++;
         $display("FAIL sat_group: data=%h mask=%b required 000080007fff 011", out_data, out_lane_mask);
      end
      checks++;
      if (sat_count !== SC_TWO) begin
         failures++; $display("FAIL sat_count_two: sat_count=%0d required %0d", sat_count, SC_TWO);
      end
   endtask

   task automatic test_rounding_partial();
      do_reset();
      out_ready = 1'b1;
      send(32'd5, 5'd1, 1'b0);
      send(32'hFFFF_FFFB, 5'd1, 1'b0);
      send(32'd24, 5'd4, 1'b0);
      wait_valid("round_wait");
      checks++;
      if (out_data !== 48'h0002_FFFE_0003 || out_lane_mask !== 3'b111) begin
         failures++;
         $display("FAIL round_group: data=%h mask=%b required 0002fffe0003 111", out_data, out_lane_mask);
      end
      @(negedge clk);
      send(32'd7, 5'd0, 1'b0);
      send(32'hFFFF_FFFF, 5'd0, 1'b1);
      wait_valid("partial_wait");
      checks++;
      if (out_data !== 48'h0000_FFFF_0007 || out_lane_mask !== 3'b011) begin
         failures++;
         $display("FAIL partial_group: data=%h mask=%b required 0000ffff0007 011", out_data, out_lane_mask);
      end
   endtask

   task automatic test_backpressure();
      logic [47:0] e;
      do_reset();
      out_ready = 1'b0;
      for (int g = 0; g < 4; g++)
         for (int k = 0; k < 3; k++)
            send(32'(g*16 + k + 1), 5'd0, 1'b0);
      checks++;
      if ({in_ready, out_valid} !== 2'b01 || out_data !== 48'h0003_0002_0001) begin
         failures++;
         $display("FAIL bp_full: ready/valid=%b data=%h required 01 000300020001", {in_ready, out_valid}, out_data);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 48'h0003_0002_0001) begin
         failures++; $display("FAIL bp_stable: valid=%b data=%h required 1 000300020001", out_valid, out_data);
      end
      out_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         e = {16'(g*16 + 3), 16'(g*16 + 2), 16'(g*16 + 1)};
         checks++;
         if (out_valid !== 1'b1 || out_data !== e || out_lane_mask !== 3'b111) begin
            failures++;
            $display("FAIL bp_drain%0d: valid=%b data=%h mask=%b required 1 %h 111", g, out_valid, out_data, out_lane_mask, e);
         end
         @(negedge clk);
      end
      checks++;
      if ({out_valid, driving_cons, in_ready} !== 3'b011) begin
         failures++; $display("FAIL bp_empty: valid/drv/ready=%b required 011", {out_valid, driving_cons, in_ready});
      end
      @(negedge clk);
      checks++;
      if (driving_cons !== 1'b1) begin
         failures++; $display("FAIL bp_rel: driving_cons=%b required 1", driving_cons);
      end
      @(negedge clk);
      checks++;
      if (driving_cons !== 1'b0) begin
         failures++; $display("FAIL bp_idle: driving_cons=%b required 0", driving_cons);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(32'h100 + 32'(i), 5'd0, 1'b0);
      send(32'h55, 5'd0, 1'b0);
      wait_valid("mid_wait");
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      checks++;
      if ({out_valid, driving_cons, in_ready} !== 3'b001 || out_lane_mask !== 3'b000) begin
         failures++;
         $display("FAIL mid_reset: valid/drv/ready=%b mask=%b required 001 000", {out_valid, driving_cons, in_ready}, out_lane_mask);
      end
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({out_valid, driving_cons} !== 2'b00) begin
         failures++; $display("FAIL mid_quiet: valid/drv=%b required 00", {out_valid, driving_cons});
      end
      send(32'h9, 5'd0, 1'b1);
      wait_valid("mid_new_wait");
      checks++;
      if (out_data !== 48'h0000_0000_0009 || out_lane_mask !== 3'b001) begin
         failures++;
         $display("FAIL mid_new_group: data=%h mask=%b required 000000000009 001", out_data, out_lane_mask);
      end
   endtask

   initial begin
      rst_in = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      shift_amt = '0; out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_saturation();
      test_rounding_partial();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
